// File: rtl/neuai_key_debounce.sv
// 4-key debouncer: 2-flop sync, per-key stability counter, press/release pulses, key_valid/key_code one clk after a press.
// Latency DEBOUNCE_CYCLES+2 clks, no backpressure; `define KEY_REPEAT_EN adds per-key auto-repeat while held.
module neuai_key_debounce #(
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter int REPEAT_DELAY    = 6000000,
   parameter int REPEAT_PERIOD   = 1200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key,
   output logic [3:0] key_level,
   output logic [3:0] key_press,
   output logic [3:0] key_release,
   output logic       key_valid,
   output logic [1:0] key_code
);

   localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [DW-1:0] db_cnt [4];
   logic [3:0]    differ;
   logic [3:0]    accept;
   logic [3:0]    press_nxt;
   logic [3:0]    release_nxt;
   logic [3:0]    rep_hit;
   logic [1:0]    low_idx;

   always_comb begin
      differ = sync2 ^ key_level;
      accept = '0;
      for (int i = 0; i < 4; i++) begin
         accept[i] = differ[i] && (db_cnt[i] == DB_LAST);
      end
      press_nxt   = (accept & ~sync2) | rep_hit;
      release_nxt = accept & sync2;
   end

   // lowest pulsing index wins; simultaneous higher presses are not queued
   always_comb begin
      low_idx = '0;
      for (int i = 3; i >= 0; i--) begin
         if (key_press[i]) low_idx = 2'(i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1       <= '1;
         sync2       <= '1;
         key_level   <= '1;
         key_press   <= '0;
         key_release <= '0;
         key_valid   <= 1'b0;
         key_code    <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         for (int i = 0; i < 4; i++) begin
            if (accept[i]) begin
               key_level[i] <= sync2[i];
               db_cnt[i]    <= '0;
            end else if (differ[i]) begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end else begin
               db_cnt[i] <= '0;
            end
         end
         key_press   <= press_nxt;
         key_release <= release_nxt;
         key_valid   <= |key_press;
         if (|key_press) key_code <= low_idx;
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW   = (HMAX > 2) ? $clog2(HMAX) : 1;
   localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

   logic [HW-1:0] hold_cnt [4];
   logic [3:0]    rep_on;

   // a release edge suppresses any repeat that would land on it
   always_comb begin
      rep_hit = '0;
      for (int i = 0; i < 4; i++) begin
         rep_hit[i] = !key_level[i] && !accept[i] &&
                      (hold_cnt[i] == (rep_on[i] ? PERIOD_LAST : DELAY_LAST));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_on <= '0;
         for (int i = 0; i < 4; i++) hold_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (key_level[i] || accept[i]) begin
               hold_cnt[i] <= '0;
               rep_on[i]   <= 1'b0;
            end else if (rep_hit[i]) begin
               hold_cnt[i] <= '0;
               rep_on[i]   <= 1'b1;
            end else begin
               hold_cnt[i] <= hold_cnt[i] + HW'(1);
            end
         end
      end
   end
`else
   localparam int repeat_unused = REPEAT_DELAY + REPEAT_PERIOD;
   assign rep_hit = '0;
`endif

endmodule

// File: tb/tb_neuai_key_debounce.sv
// Bench for neuai_key_debounce: vector table, reset/repeat corner sequences, randomized run against a reference model.
module tb_neuai_key_debounce;
   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;
`ifdef KEY_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key;
   logic [3:0] key_level, key_press, key_release;
   logic       key_valid;
   logic [1:0] key_code;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   neuai_key_debounce #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key        (key),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_release(key_release),
      .key_valid  (key_valid),
      .key_code   (key_code)
   );

   typedef struct {
      logic [3:0] key;
      logic [3:0] level;
      logic [3:0] press;
      logic [3:0] rel;
      logic       valid;
      logic [1:0] code;
   } vec_t;

   vec_t vt[$];

   // reference model state: raw-input delay line plus run lengths of disagreement
   logic [3:0] m_s1, m_s2, m_level, m_press, m_rel;
   logic       m_valid;
   logic [1:0] m_code;
   int         run[4];
   int         acc[4];
   int         cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [14:0] outs();
      return {key_level, key_press, key_release, key_valid, key_code};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_press(output int n);
      n = -1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (key_press != 4'b0) begin
            n = c;
            break;
         end
      end
   endtask

   task automatic add(input logic [3:0] k, input logic [3:0] l, input logic [3:0] p,
                      input logic [3:0] r, input logic v, input logic [1:0] c, input int n);
      vec_t e;
      e.key = k; e.level = l; e.press = p; e.rel = r; e.valid = v; e.code = c;
      for (int i = 0; i < n; i++) vt.push_back(e);
   endtask

   task automatic model_reset();
      m_s1 = '1; m_s2 = '1; m_level = '1;
      m_press = '0; m_rel = '0; m_valid = 1'b0; m_code = '0;
      cyc = 0;
      for (int i = 0; i < 4; i++) begin
         run[i] = 0;
         acc[i] = 0;
      end
   endtask

   task automatic model_step(input logic [3:0] k);
      logic [3:0] np, nr;
      logic       old;
      int         e;
      np = '0;
      nr = '0;
      m_valid = (m_press != 4'b0);
      for (int i = 3; i >= 0; i--) begin
         if (m_press[i]) m_code = 2'(i);
      end
      for (int i = 0; i < 4; i++) begin
         old = m_level[i];
         if (m_s2[i] != m_level[i]) begin
            run[i]++;
            if (run[i] == D) begin
               run[i]     = 0;
               m_level[i] = m_s2[i];
               if (!m_s2[i]) begin
                  np[i]  = 1'b1;
                  acc[i] = cyc;
               end else begin
                  nr[i] = 1'b1;
               end
            end
         end else begin
            run[i] = 0;
         end
         if (REP && !old && !nr[i]) begin
            e = cyc - acc[i];
            if (e >= RD && (e - RD) % RP == 0) np[i] = 1'b1;
         end
      end
      m_press = np;
      m_rel   = nr;
      m_s2    = m_s1;
      m_s1    = k;
      cyc++;
   endtask

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [3:0] nk;
      int prob;
      logic exp_p, exp_r;

      // reset with all keys held low
      rst = 1'b0;
      key = 4'b0000;
      repeat (3) tick();
      check("reset_outs", outs(), {4'hF, 4'h0, 4'h0, 1'b0, 2'd0});
      @(negedge clk) rst = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         check($sformatf("rst_release_wait%0d", c), outs(), {4'hF, 4'h0, 4'h0, 1'b0, 2'd0});
      end
      tick();
      check("rst_release_accept", outs(), {4'h0, 4'hF, 4'h0, 1'b0, 2'd0});
      tick();
      check("rst_release_valid", outs(), {4'h0, 4'h0, 4'h0, 1'b1, 2'd0});
      @(negedge clk) key = 4'b1111;
      repeat (12) tick();

      // vector table: clean press/release, simultaneous press, bounce
      add(4'b1011, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 5);
      add(4'b1011, 4'b1011, 4'b0100, 4'b0000, 1'b0, 2'd0, 1);
      add(4'b1011, 4'b1011, 4'b0000, 4'b0000, 1'b1, 2'd2, 1);
      add(4'b1111, 4'b1011, 4'b0000, 4'b0000, 1'b0, 2'd2, 5);
      add(4'b1111, 4'b1111, 4'b0000, 4'b0100, 1'b0, 2'd2, 1);
      add(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd2, 1);
      add(4'b0101, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd2, 5);
      add(4'b0101, 4'b0101, 4'b1010, 4'b0000, 1'b0, 2'd2, 1);
      add(4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b1, 2'd1, 1);
      add(4'b1111, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'd1, 5);
      add(4'b1111, 4'b1111, 4'b0000, 4'b1010, 1'b0, 2'd1, 1);
      add(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd1, 1);
      for (int b = 0; b < 5; b++) begin
         add(4'b1101, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd1, 3);
         add(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd1, 1);
      end
      add(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd1, 4);
      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk) key = vt[i].key;
         tick();
         check($sformatf("vec%0d", i), outs(),
               {vt[i].level, vt[i].press, vt[i].rel, vt[i].valid, vt[i].code});
      end

      // reset in the middle of debounce, then in the middle of a hold
      @(negedge clk) key = 4'b1110;
      repeat (3) tick();
      @(negedge clk) rst = 1'b0;
      #1 check("mid_debounce_reset", outs(), {4'hF, 4'h0, 4'h0, 1'b0, 2'd0});
      @(negedge clk) rst = 1'b1;
      wait_press(n);
      check("reaccept_after_debounce_reset", n, 6);
      repeat (2) tick();
      @(negedge clk) rst = 1'b0;
      #1 check("mid_hold_reset", outs(), {4'hF, 4'h0, 4'h0, 1'b0, 2'd0});
      @(negedge clk) rst = 1'b1;
      wait_press(n);
      check("reaccept_after_hold_reset", n, 6);
      @(negedge clk) key = 4'b1111;
      repeat (12) tick();

      // long hold of key[0]: auto-repeat timing and release
      @(negedge clk) key = 4'b1110;
      wait_press(n);
      check("hold_accept_latency", n, 6);
      for (int off = 1; off <= 45; off++) begin
         if (off == 31) begin
            @(negedge clk) key = 4'b1111;
         end
         tick();
         exp_p = REP && off < 36 && off >= RD && ((off - RD) % RP == 0);
         exp_r = (off == 36);
         check($sformatf("hold_off%0d", off), {key_press[0], key_release[0]}, {exp_p, exp_r});
      end

      // randomized run against the reference model
      @(negedge clk);
      rst = 1'b0;
      key = 4'b1111;
      repeat (2) tick();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      prob = 8;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) prob = $urandom_range(2, 40);
         nk = key;
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, prob - 1) == 0) nk[i] = ~nk[i];
         end
         key = nk;
         tick();
         model_step(nk);
         check($sformatf("random_cyc%0d", c), outs(), {m_level, m_press, m_rel, m_valid, m_code});
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/neuai_key_debounce.md
NEUAI_KEY_DEBOUNCE -- requirements
Module: neuai_key_debounce

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 240000, clocks an input must stay stable before acceptance (20 ms at 12 MHz).
REQ-002 Parameter: REPEAT_DELAY, default 6000000, clocks from accepted press to first auto-repeat (used only with KEY_REPEAT_EN).
REQ-003 Parameter: REPEAT_PERIOD, default 1200000, clocks between subsequent auto-repeats (used only with KEY_REPEAT_EN).
REQ-004 Port: clk  input  1  system clock, all logic on rising edge.
REQ-005 Port: rst  input  1  asynchronous active-low reset.
REQ-006 Port: key  input  4  raw board keys, asynchronous, active-low (0 = pressed).
REQ-007 Port: key_level  output  4  debounced key state, active-low.
REQ-008 Port: key_press  output  4  one-clk pulse per accepted press (and per repeat), active-high.
REQ-009 Port: key_release  output  4  one-clk pulse per accepted release, active-high.
REQ-010 Port: key_valid  output  1  one-clk pulse, a key event is on key_code.
REQ-011 Port: key_code  output  2  index of key reported by key_valid; holds between pulses.

Function
REQ-012 Each key bit SHALL pass a 2-flop synchronizer before any other use.
REQ-013 Per key: synchronized value != key_level -> debounce counter increments; equal -> counter clears to 0.
REQ-014 Counter reaching DEBOUNCE_CYCLES-1 while still differing -> key_level bit takes synchronized value, counter clears.
REQ-015 Any glitch shorter than DEBOUNCE_CYCLES synchronized clocks SHALL leave key_level unchanged.
REQ-016 Latency: clean input edge to key_level change = exactly DEBOUNCE_CYCLES+2 clk rising edges.
REQ-017 key_press[i] SHALL assert on the same edge key_level[i] goes 1->0; key_release[i] on the same edge it goes 0->1; each high exactly one clk.
REQ-018 key_valid SHALL pulse one clk after any key_press bit pulses; key_code = lowest index among pulsing key_press bits.
REQ-019 Simultaneous presses: all bits appear in key_press; only lowest index reported on key_code; no queuing of others.
REQ-020 Releases SHALL NOT generate key_valid.
REQ-021 Counter widths SHALL be sized to hold the largest parameter value without wrap.

Reset
REQ-022 While rst=0: synchronizers and key_level = 4'b1111, key_press/key_release = 0, key_valid = 0, key_code = 0, all counters = 0.
REQ-023 Reset mid-debounce or mid-hold SHALL discard progress; after release a key held low is re-accepted as a new press after DEBOUNCE_CYCLES+2 clks.

Configuration
REQ-024 Macro KEY_REPEAT_EN defined: per key hold counter; while key_level[i]=0, extra key_press[i] pulse (and key_valid) at REPEAT_DELAY clks after acceptance, then every REPEAT_PERIOD clks until release.
REQ-025 Hold counter SHALL clear on release and on reset; repeat pulses never coincide with key_release.
REQ-026 Macro KEY_REPEAT_EN undefined: no hold counters synthesized; exactly one key_press per accepted press; REPEAT_* parameters ignored.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 Reset: rst=0 with key=4'b0000 -> key_level=4'b1111, all pulses 0; rst released -> key_level=4'b0000 after 6 clks, key_press=4'b1111 one clk, key_valid next clk with key_code=0.
REQ-028 Clean press key[2] low held -> key_level[2]=0 on edge 6, key_press=4'b0100 one clk, key_valid with key_code=2 on edge 7; release -> key_release=4'b0100 6 clks later, no key_valid.
REQ-029 Bounce: key[1] low 3 clks, high 1 clk, repeated 5 times, then high -> no key_press, key_level stays 4'b1111.
REQ-030 Simultaneous key[3] and key[1] low same clk -> key_press=4'b1010 one clk, single key_valid with key_code=1.
REQ-031 KEY_REPEAT_EN, key[0] held 30 clks after acceptance -> key_press[0] pulses at +0, +10, +13, +16, ... +28; none after release; undefined macro -> only +0 pulse.
